// File: rtl/tdc_fifo_reader_pkg.sv
// Shared definitions for the TDC FIFO-to-byte-stream framer.
package tdc_fifo_reader_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    LATCH   = 3'd3,
    SEND    = 3'd4,
    WAIT_TX = 3'd5,
    DONE    = 3'd6
  } state_e;

  localparam int          FRAME_LEN     = 6;
  localparam logic [7:0]  SYNC_BYTE_DEF = 8'hA5;

endpackage

// File: rtl/tdc_fifo_reader.sv
// Pops one 32-bit TDC word per frame and streams it as SYNC, 4 data bytes, XOR checksum.
module tdc_fifo_reader
  import tdc_fifo_reader_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE       = SYNC_BYTE_DEF,
  parameter int         FIFO_RD_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fifo_empty,
  input  logic [31:0] fifo_dout,
  output logic        fifo_rd_en,
  input  logic        tx_busy,
  output logic        new_tx_data,
  output logic [7:0]  tx_data,
  input  logic        pause,
  output logic        frame_sent,
  output logic [15:0] frame_count,
  output logic        busy
);

  localparam logic [1:0] WAIT_LAST = 2'(FIFO_RD_LATENCY - 1);
  localparam logic [2:0] LAST_IDX  = 3'(FRAME_LEN - 1);

  state_e      state;
  logic [31:0] word;
  logic [7:0]  chk;
  logic [2:0]  idx;
  logic [1:0]  wait_cnt;
  logic        first_wait;
  logic [7:0]  byte_sel;

  always_comb begin
    byte_sel = chk;
    case (idx)
      3'd0:    byte_sel = SYNC_BYTE;
      3'd1:    byte_sel = word[31:24];
      3'd2:    byte_sel = word[23:16];
      3'd3:    byte_sel = word[15:8];
      3'd4:    byte_sel = word[7:0];
      default: byte_sel = chk;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      fifo_rd_en  <= 1'b0;
      new_tx_data <= 1'b0;
      tx_data     <= 8'h00;
      frame_sent  <= 1'b0;
      frame_count <= 16'h0000;
      busy        <= 1'b0;
      word        <= 32'h0;
      chk         <= 8'h00;
      idx         <= 3'd0;
      wait_cnt    <= 2'd0;
      first_wait  <= 1'b0;
    end else begin
      fifo_rd_en  <= 1'b0;
      new_tx_data <= 1'b0;
      frame_sent  <= 1'b0;
      case (state)
        IDLE: begin
          if (!fifo_empty && !pause && !tx_busy) begin
            state      <= RD_REQ;
            fifo_rd_en <= 1'b1;
            busy       <= 1'b1;
          end
        end
        RD_REQ: begin
          state    <= RD_WAIT;
          wait_cnt <= 2'd0;
        end
        RD_WAIT: begin
          if (wait_cnt == WAIT_LAST) state <= LATCH;
          else                       wait_cnt <= wait_cnt + 2'd1;
        end
        LATCH: begin
          word  <= fifo_dout;
          chk   <= fifo_dout[31:24] ^ fifo_dout[23:16] ^ fifo_dout[15:8] ^ fifo_dout[7:0];
          idx   <= 3'd0;
          state <= SEND;
        end
        SEND: begin
          tx_data     <= byte_sel;
          new_tx_data <= 1'b1;
          first_wait  <= 1'b1;
          state       <= WAIT_TX;
        end
        WAIT_TX: begin
          // The transmitter raises busy one cycle after the strobe, so skip the first look.
          if (first_wait) begin
            first_wait <= 1'b0;
          end else if (!tx_busy) begin
            if (idx == LAST_IDX) begin
              state      <= DONE;
              frame_sent <= 1'b1;
            end else begin
              idx   <= idx + 3'd1;
              state <= SEND;
            end
          end
        end
        DONE: begin
          frame_count <= frame_count + 16'd1;
          busy        <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tdc_fifo_reader.sv
// Directed bench: instance 0 uses read latency 1, instance 1 uses read latency 2.
module tb_tdc_fifo_reader;

  logic        clk = 1'b0;
  logic        rst        [2];
  logic        pause      [2];
  logic        fifo_empty [2] = '{1'b1, 1'b1};
  logic [31:0] fifo_dout  [2] = '{32'hDEADBEEF, 32'hDEADBEEF};
  logic        tx_busy    [2] = '{1'b0, 1'b0};
  logic        fifo_rd_en [2];
  logic        new_tx_data[2];
  logic [7:0]  tx_data    [2];
  logic        frame_sent [2];
  logic [15:0] frame_count[2];
  logic        busy       [2];

  // FIFO / transmitter model state
  logic [31:0] fmem [2][16];
  int          fhead [2] = '{0, 0};
  int          ftail [2] = '{0, 0};
  logic [31:0] pend  [2];
  int          pcnt  [2] = '{0, 0};
  int          lat   [2] = '{1, 2};
  int          txlen [2] = '{10, 3};
  int          txc   [2] = '{0, 0};
  logic        tx_hold [2] = '{1'b0, 1'b0};
  logic [7:0]  rx   [2][128];
  int          rxn   [2] = '{0, 0};
  int          nreads[2] = '{0, 0};
  int          nsent [2] = '{0, 0};
  int          rd_empty_viol[2] = '{0, 0};
  int          last_sent[2] = '{-1000, -1000};
  int          min_gap  [2] = '{1000, 1000};
  int          cyc = 0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  tdc_fifo_reader #(.SYNC_BYTE(8'hA5), .FIFO_RD_LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst[0]), .fifo_empty(fifo_empty[0]), .fifo_dout(fifo_dout[0]),
    .fifo_rd_en(fifo_rd_en[0]), .tx_busy(tx_busy[0]), .new_tx_data(new_tx_data[0]),
    .tx_data(tx_data[0]), .pause(pause[0]), .frame_sent(frame_sent[0]),
    .frame_count(frame_count[0]), .busy(busy[0]));

  tdc_fifo_reader #(.SYNC_BYTE(8'hA5), .FIFO_RD_LATENCY(2)) u_l2 (
    .clk(clk), .rst(rst[1]), .fifo_empty(fifo_empty[1]), .fifo_dout(fifo_dout[1]),
    .fifo_rd_en(fifo_rd_en[1]), .tx_busy(tx_busy[1]), .new_tx_data(new_tx_data[1]),
    .tx_data(tx_data[1]), .pause(pause[1]), .frame_sent(frame_sent[1]),
    .frame_count(frame_count[1]), .busy(busy[1]));

  always @(negedge clk) begin
    cyc = cyc + 1;
    for (int g = 0; g < 2; g++) begin
      if (fifo_rd_en[g]) begin
        nreads[g] = nreads[g] + 1;
        if (cyc - last_sent[g] < min_gap[g]) min_gap[g] = cyc - last_sent[g];
        if (fhead[g] == ftail[g]) rd_empty_viol[g] = rd_empty_viol[g] + 1;
        else begin
          pend[g]  = fmem[g][fhead[g]];
          fhead[g] = fhead[g] + 1;
          pcnt[g]  = lat[g];
        end
      end else if (pcnt[g] > 0) begin
        pcnt[g] = pcnt[g] - 1;
        if (pcnt[g] == 0) fifo_dout[g] = pend[g];
      end
      fifo_empty[g] = (fhead[g] == ftail[g]);
      if (new_tx_data[g]) begin
        rx[g][rxn[g]] = tx_data[g];
        rxn[g] = rxn[g] + 1;
        txc[g] = txlen[g];
      end else if (txc[g] > 0) txc[g] = txc[g] - 1;
      tx_busy[g] = tx_hold[g] || (txc[g] > 0);
      if (frame_sent[g]) begin
        nsent[g] = nsent[g] + 1;
        last_sent[g] = cyc;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input int g, input logic [31:0] w);
    fmem[g][ftail[g]] = w;
    ftail[g] = ftail[g] + 1;
  endtask

  task automatic wait_sent(input int g, input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (nsent[g] >= target) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  task automatic wait_rx(input int g, input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (rxn[g] >= target) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = '{1'b1, 1'b1};
    pause = '{1'b0, 1'b0};
    repeat (3) tick();
    for (int g = 0; g < 2; g++) begin
      n_checks += 6;
      if (fifo_rd_en[g] !== 1'b0)    begin n_fail++; $display("FAIL reset_rd_en[%0d] got %b exp 0", g, fifo_rd_en[g]); end
      if (new_tx_data[g] !== 1'b0)   begin n_fail++; $display("FAIL reset_new_tx[%0d] got %b exp 0", g, new_tx_data[g]); end
      if (tx_data[g] !== 8'h00)      begin n_fail++; $display("FAIL reset_tx_data[%0d] got %h exp 00", g, tx_data[g]); end
      if (frame_sent[g] !== 1'b0)    begin n_fail++; $display("FAIL reset_frame_sent[%0d] got %b exp 0", g, frame_sent[g]); end
      if (frame_count[g] !== 16'h0)  begin n_fail++; $display("FAIL reset_frame_count[%0d] got %h exp 0", g, frame_count[g]); end
      if (busy[g] !== 1'b0)          begin n_fail++; $display("FAIL reset_busy[%0d] got %b exp 0", g, busy[g]); end
    end
    rst = '{1'b0, 1'b0};
    tick();
  endtask

  task automatic test_empty();
    int act = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (fifo_rd_en[0] || new_tx_data[0] || busy[0]) act++;
    end
    n_checks++;
    if (act !== 0) begin n_fail++; $display("FAIL empty_idle active_cycles got %0d exp 0", act); end
  endtask

  task automatic test_single();
    logic [7:0] exp [6] = '{8'hA5, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
    int b = rxn[0], r = nreads[0], s = nsent[0];
    bit ok;
    push(0, 32'h1234_ABCD);
    wait_sent(0, s + 1, 2000, ok);
    tick(); tick();
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL single_timeout frame_sent count got %0d exp %0d", nsent[0], s + 1); end
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (rx[0][b + i] !== exp[i]) begin n_fail++; $display("FAIL single_byte%0d got %h exp %h", i, rx[0][b + i], exp[i]); end
    end
    n_checks += 5;
    if (rxn[0] - b !== 6)        begin n_fail++; $display("FAIL single_nbytes got %0d exp 6", rxn[0] - b); end
    if (nreads[0] - r !== 1)     begin n_fail++; $display("FAIL single_reads got %0d exp 1", nreads[0] - r); end
    if (nsent[0] - s !== 1)      begin n_fail++; $display("FAIL single_sent got %0d exp 1", nsent[0] - s); end
    if (frame_count[0] !== 16'd1) begin n_fail++; $display("FAIL single_count got %0d exp 1", frame_count[0]); end
    if (busy[0] !== 1'b0)        begin n_fail++; $display("FAIL single_busy_after got %b exp 0", busy[0]); end
  endtask

  task automatic test_pause();
    logic [7:0] exp [18] = '{8'hA5, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44,
                             8'hA5, 8'h55, 8'h66, 8'h77, 8'h88, 8'hCC,
                             8'hA5, 8'h99, 8'hAA, 8'hBB, 8'hCC, 8'h44};
    int b = rxn[0], r = nreads[0], s = nsent[0];
    bit ok1, ok2, ok3;
    push(0, 32'h1122_3344);
    push(0, 32'h5566_7788);
    push(0, 32'h99AA_BBCC);
    wait_rx(0, b + 2, 2000, ok1);
    pause[0] = 1'b1;
    wait_sent(0, s + 1, 2000, ok2);
    repeat (100) tick();
    n_checks += 4;
    if (!(ok1 && ok2))         begin n_fail++; $display("FAIL pause_timeout frame1 got sent=%0d exp %0d", nsent[0] - s, 1); end
    if (rxn[0] - b !== 6)      begin n_fail++; $display("FAIL pause_frame1_bytes got %0d exp 6", rxn[0] - b); end
    if (nreads[0] - r !== 1)   begin n_fail++; $display("FAIL pause_reads_held got %0d exp 1", nreads[0] - r); end
    if (busy[0] !== 1'b0)      begin n_fail++; $display("FAIL pause_busy got %b exp 0", busy[0]); end
    pause[0] = 1'b0;
    wait_sent(0, s + 3, 3000, ok3);
    tick(); tick();
    n_checks += 3;
    if (!ok3)                  begin n_fail++; $display("FAIL pause_timeout resume got sent=%0d exp 3", nsent[0] - s); end
    if (nreads[0] - r !== 3)   begin n_fail++; $display("FAIL pause_total_reads got %0d exp 3", nreads[0] - r); end
    if (frame_count[0] !== 16'd4) begin n_fail++; $display("FAIL pause_count got %0d exp 4", frame_count[0]); end
    for (int i = 0; i < 18; i++) begin
      n_checks++;
      if (rx[0][b + i] !== exp[i]) begin n_fail++; $display("FAIL pause_byte%0d got %h exp %h", i, rx[0][b + i], exp[i]); end
    end
  endtask

  task automatic test_back_to_back();
    n_checks += 2;
    if (min_gap[0] < 2) begin n_fail++; $display("FAIL b2b_gap got %0d exp >=2", min_gap[0]); end
    if (rd_empty_viol[0] !== 0) begin n_fail++; $display("FAIL rd_while_empty got %0d exp 0", rd_empty_viol[0]); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp [6] = '{8'hA5, 8'h0B, 8'hAD, 8'h00, 8'h02, 8'hA4};
    int b = rxn[0], r = nreads[0], b2, s;
    bit ok1, ok2;
    push(0, 32'hCAFE_0001);
    push(0, 32'h0BAD_0002);
    wait_rx(0, b + 3, 2000, ok1);
    rst[0] = 1'b1;
    tick();
    n_checks += 7;
    if (!ok1)                     begin n_fail++; $display("FAIL rstmid_timeout bytes got %0d exp 3", rxn[0] - b); end
    if (fifo_rd_en[0] !== 1'b0)   begin n_fail++; $display("FAIL rstmid_rd_en got %b exp 0", fifo_rd_en[0]); end
    if (new_tx_data[0] !== 1'b0)  begin n_fail++; $display("FAIL rstmid_new_tx got %b exp 0", new_tx_data[0]); end
    if (tx_data[0] !== 8'h00)     begin n_fail++; $display("FAIL rstmid_tx_data got %h exp 00", tx_data[0]); end
    if (frame_sent[0] !== 1'b0)   begin n_fail++; $display("FAIL rstmid_sent got %b exp 0", frame_sent[0]); end
    if (frame_count[0] !== 16'h0) begin n_fail++; $display("FAIL rstmid_count got %h exp 0", frame_count[0]); end
    if (busy[0] !== 1'b0)         begin n_fail++; $display("FAIL rstmid_busy got %b exp 0", busy[0]); end
    rst[0] = 1'b0;
    b2 = rxn[0];
    s  = nsent[0];
    wait_sent(0, s + 1, 2000, ok2);
    tick(); tick();
    n_checks += 4;
    if (!ok2)                     begin n_fail++; $display("FAIL rstmid_timeout next frame sent=%0d exp 1", nsent[0] - s); end
    if (rxn[0] - b2 !== 6)        begin n_fail++; $display("FAIL rstmid_nbytes got %0d exp 6", rxn[0] - b2); end
    if (nreads[0] - r !== 2)      begin n_fail++; $display("FAIL rstmid_reads got %0d exp 2", nreads[0] - r); end
    if (frame_count[0] !== 16'd1) begin n_fail++; $display("FAIL rstmid_count_after got %0d exp 1", frame_count[0]); end
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (rx[0][b2 + i] !== exp[i]) begin n_fail++; $display("FAIL rstmid_byte%0d got %h exp %h", i, rx[0][b2 + i], exp[i]); end
    end
  endtask

  task automatic test_stall();
    logic [7:0] exp [6] = '{8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04};
    int b = rxn[0], s = nsent[0];
    bit ok1, ok2;
    push(0, 32'h0102_0304);
    wait_rx(0, b + 2, 2000, ok1);
    tx_hold[0] = 1'b1;
    repeat (200) tick();
    n_checks += 3;
    if (!ok1)               begin n_fail++; $display("FAIL stall_timeout bytes got %0d exp 2", rxn[0] - b); end
    if (rxn[0] - b !== 2)   begin n_fail++; $display("FAIL stall_bytes_held got %0d exp 2", rxn[0] - b); end
    if (busy[0] !== 1'b1)   begin n_fail++; $display("FAIL stall_busy got %b exp 1", busy[0]); end
    tx_hold[0] = 1'b0;
    wait_sent(0, s + 1, 2000, ok2);
    tick();
    n_checks++;
    if (!ok2) begin n_fail++; $display("FAIL stall_timeout resume sent=%0d exp 1", nsent[0] - s); end
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (rx[0][b + i] !== exp[i]) begin n_fail++; $display("FAIL stall_byte%0d got %h exp %h", i, rx[0][b + i], exp[i]); end
    end
  endtask

  task automatic test_wrap();
    int s = nsent[0];
    bit ok;
    force u_l1.frame_count = 16'hFFFF;
    tick();
    release u_l1.frame_count;
    tick();
    push(0, 32'h0000_0000);
    wait_sent(0, s + 1, 2000, ok);
    tick(); tick();
    n_checks += 2;
    if (!ok)                      begin n_fail++; $display("FAIL wrap_sent got %0d exp 1", nsent[0] - s); end
    if (frame_count[0] !== 16'h0) begin n_fail++; $display("FAIL wrap_count got %h exp 0000", frame_count[0]); end
  endtask

  task automatic test_latency2();
    logic [7:0] exp [6] = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF};
    int b = rxn[1], s = nsent[1];
    bit ok;
    push(1, 32'h0000_00FF);
    wait_sent(1, s + 1, 2000, ok);
    tick(); tick();
    n_checks += 3;
    if (!ok)                      begin n_fail++; $display("FAIL lat2_timeout sent=%0d exp 1", nsent[1] - s); end
    if (nreads[1] !== 1)          begin n_fail++; $display("FAIL lat2_reads got %0d exp 1", nreads[1]); end
    if (frame_count[1] !== 16'd1) begin n_fail++; $display("FAIL lat2_count got %0d exp 1", frame_count[1]); end
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (rx[1][b + i] !== exp[i]) begin n_fail++; $display("FAIL lat2_byte%0d got %h exp %h", i, rx[1][b + i], exp[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_empty();
    test_single();
    test_pause();
    test_back_to_back();
    test_reset_mid();
    test_stall();
    test_wrap();
    test_latency2();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
